// File: rtl/v20_bus_master.sv
// NEC V20 min-mode bus-cycle initiator: turns single-byte read/write requests into
// T1-T4 multiplexed bus cycles, inserting TW states while the slave holds READY low.
module v20_bus_master #(
    parameter int unsigned TSTATE_CLKS = 2,
    parameter int unsigned WAIT_MAX    = 255
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic [19:0] iReqAddr,
    input  logic [7:0]  iReqData,
    input  logic        iReqWr,
    input  logic        iReqIo,
    output logic        oRspValid,
    output logic [7:0]  oRspData,
    output logic        oRspErr,
    output logic        oBusClk,
    output logic        oAle,
    output logic        oSso,
    output logic        oIom,
    output logic        oDtr,
    output logic [11:0] oAh,
    output logic [7:0]  oAd,
    output logic        oAdOe,
    input  logic [7:0]  iAd,
    input  logic        iReady
);

    localparam int unsigned PW = $clog2(TSTATE_CLKS);
    localparam logic [PW-1:0] PHASE_LAST = PW'(TSTATE_CLKS - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(TSTATE_CLKS / 2);
    localparam logic [7:0]    WAIT_LIM   = 8'(WAIT_MAX);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_TW   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;

    logic [2:0]    r_state;
    logic [PW-1:0] r_phase;
    logic [19:0]   r_addr;
    logic [7:0]    r_data;
    logic          r_wr;
    logic          r_io;
    logic [7:0]    r_wait_cnt;
    logic          r_err;
    logic [7:0]    r_cap;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_err;

    logic [2:0]    w_state_nxt;
    logic          w_last;
    logic          w_accept;
    logic          w_sample;
    logic          w_timeout;
    logic          w_active;

    assign w_last    = (r_phase == PHASE_LAST);
    assign w_accept  = iReqValid & r_req_ready;
    assign w_sample  = ((r_state == ST_T3) || (r_state == ST_TW)) && w_last;
    assign w_timeout = (r_wait_cnt == WAIT_LIM);
    assign w_active  = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_T1;
            ST_T1:   if (w_last) w_state_nxt = ST_T2;
            ST_T2:   if (w_last) w_state_nxt = ST_T3;
            ST_T3, ST_TW: begin
                if (w_last) begin
                    w_state_nxt = (iReady || w_timeout) ? ST_T4 : ST_TW;
                end
            end
            ST_T4:   if (w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr        <= 1'b0;
            r_io        <= 1'b0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_cap       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Phase free-runs, but is realigned so T1 always starts at phase 0.
            r_phase     <= (w_accept || w_last) ? '0 : r_phase + PW'(1);
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (r_state == ST_T4) && w_last;

            if (w_accept) begin
                r_addr     <= iReqAddr;
                r_data     <= iReqData;
                r_wr       <= iReqWr;
                r_io       <= iReqIo;
                r_wait_cnt <= '0;
                r_err      <= 1'b0;
                r_cap      <= '0;
            end

            if (w_sample) begin
                if (iReady) begin
                    r_cap <= iAd;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end

            // Response fields only change at completion so they hold between pulses.
            if ((r_state == ST_T4) && w_last) begin
                r_rsp_err  <= r_err;
                r_rsp_data <= r_err ? 8'hFF : (r_wr ? 8'h00 : r_cap);
            end
        end
    end

    assign oReqReady = r_req_ready;
    assign oRspValid = r_rsp_valid;
    assign oRspData  = r_rsp_data;
    assign oRspErr   = r_rsp_err;
    assign oBusClk   = (r_phase < PHASE_HALF);

    assign oAle  = (r_state == ST_T1);
    assign oSso  = ~w_active;
    assign oIom  = w_active & r_io;
    assign oDtr  = w_active & r_wr;
    assign oAh   = !w_active ? 12'h000 : (r_io ? {4'h0, r_addr[15:8]} : r_addr[19:8]);
    assign oAdOe = (r_state == ST_T1) | (w_active & r_wr);
    assign oAd   = (r_state == ST_T1) ? r_addr[7:0] : ((w_active & r_wr) ? r_data : 8'h00);

endmodule

// File: tb/tb_v20_bus_master.sv
// Randomized scoreboard bench for v20_bus_master: a bus-level model predicts every cycle
// of each transaction from its accept time, and a reactive slave supplies READY/AD.
module tb_v20_bus_master;

    localparam int T    = 2;
    localparam int WMAX = 4;

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        io;
        int          waits;
        logic [7:0]  rd;
        int          acc;
    } txn_t;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iReqValid;
    logic        oReqReady;
    logic [19:0] iReqAddr;
    logic [7:0]  iReqData;
    logic        iReqWr;
    logic        iReqIo;
    logic        oRspValid;
    logic [7:0]  oRspData;
    logic        oRspErr;
    logic        oBusClk;
    logic        oAle;
    logic        oSso;
    logic        oIom;
    logic        oDtr;
    logic [11:0] oAh;
    logic [7:0]  oAd;
    logic        oAdOe;
    logic [7:0]  iAd;
    logic        iReady;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;
    txn_t bus_q[$];
    txn_t rsp_q[$];
    txn_t bt;
    txn_t rt;

    logic [24:0] w_vec;
    localparam logic [24:0] IDLE_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00};
    assign w_vec = {oAle, oSso, oIom, oDtr, oAdOe, oAh, oAd};

    v20_bus_master #(
        .TSTATE_CLKS(T),
        .WAIT_MAX   (WMAX)
    ) dut (
        .iClk     (iClk),
        .iReset   (iReset),
        .iReqValid(iReqValid),
        .oReqReady(oReqReady),
        .iReqAddr (iReqAddr),
        .iReqData (iReqData),
        .iReqWr   (iReqWr),
        .iReqIo   (iReqIo),
        .oRspValid(oRspValid),
        .oRspData (oRspData),
        .oRspErr  (oRspErr),
        .oBusClk  (oBusClk),
        .oAle     (oAle),
        .oSso     (oSso),
        .oIom     (oIom),
        .oDtr     (oDtr),
        .oAh      (oAh),
        .oAd      (oAd),
        .oAdOe    (oAdOe),
        .iAd      (iAd),
        .iReady   (iReady)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    function automatic int weff(input int w);
        return (w > WMAX) ? WMAX : w;
    endfunction

    function automatic int txn_len(input int w);
        return (4 + weff(w)) * T;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus model + reactive slave; expected bus state derives from offset into the cycle.
    always @(negedge iClk) begin : bus_mon
        int off, len, seg, k;
        logic [24:0] ev;
        logic [11:0] eah;
        if (chk_en) begin
            iReady = 1'($urandom);
            iAd    = 8'($urandom);
            if (bus_q.size() > 0 && cyc >= bus_q[0].acc + 1) begin
                bt  = bus_q[0];
                off = cyc - bt.acc - 1;
                len = txn_len(bt.waits);
                seg = off / T;
                if (off >= 3 * T - 1 && (off - (3 * T - 1)) % T == 0) begin
                    k      = (off - (3 * T - 1)) / T;
                    iReady = (k >= bt.waits);
                    if (k >= bt.waits) iAd = bt.rd;
                end
                eah = bt.io ? {4'h0, bt.addr[15:8]} : bt.addr[19:8];
                ev  = {seg == 0, 1'b0, bt.io, bt.wr, (seg == 0) || bt.wr, eah,
                       (seg == 0) ? bt.addr[7:0] : (bt.wr ? bt.data : 8'h00)};
                chk("bus_active", 64'(w_vec), 64'(ev));
                chk("bus_clk", 64'(oBusClk), 64'((off % T) < T / 2));
                if (off >= len - 1) void'(bus_q.pop_front());
            end else begin
                chk("bus_idle", 64'(w_vec), 64'(IDLE_VEC));
            end
        end
    end

    always @(negedge iClk) begin : rsp_mon
        int w;
        if (rsp_q.size() > 0 && cyc > rsp_q[0].acc + txn_len(rsp_q[0].waits) + 1) begin
            rt = rsp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL rsp_missing: no oRspValid, required at cycle %0d",
                     rt.acc + txn_len(rt.waits) + 1);
        end
        if (oRspValid) begin
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: oRspValid=1 required 0 (cycle %0d)", cyc);
            end else begin
                rt = rsp_q.pop_front();
                w  = rt.waits;
                chk("rsp_cycle", 64'(cyc), 64'(rt.acc + txn_len(w) + 1));
                chk("rsp_err", 64'(oRspErr), 64'(w > WMAX));
                chk("rsp_data", 64'(oRspData),
                    64'((w > WMAX) ? 8'hFF : (rt.wr ? 8'h00 : rt.rd)));
            end
        end
    end

    task automatic garbage();
        iReqAddr = 20'($urandom);
        iReqData = 8'($urandom);
        iReqWr   = 1'($urandom);
        iReqIo   = 1'($urandom);
    endtask

    task automatic idle(input int n);
        iReqValid = 1'b0;
        repeat (n) begin
            garbage();
            @(negedge iClk);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first T1 cycle.
    task automatic issue(input logic [19:0] a, input logic [7:0] d, input logic wr,
                         input logic io, input int waits, input logic [7:0] rd, input bit b2b);
        txn_t t;
        int n;
        iReqValid = 1'b1;
        iReqAddr  = a;
        iReqData  = d;
        iReqWr    = wr;
        iReqIo    = io;
        n = 0;
        while (!oReqReady && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (!oReqReady) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: oReqReady=0 required 1 within 100 cycles");
            iReqValid = 1'b0;
            return;
        end
        t.addr = a; t.data = d; t.wr = wr; t.io = io; t.waits = waits; t.rd = rd; t.acc = cyc;
        bus_q.push_back(t);
        rsp_q.push_back(t);
        @(negedge iClk);
        if (!b2b) begin
            iReqValid = 1'b0;
            garbage();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() > 0 || bus_q.size() > 0) && n < 300) begin
            @(negedge iClk);
            n++;
        end
        if (rsp_q.size() > 0 || bus_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d responses outstanding, required 0", rsp_q.size());
            rsp_q.delete();
            bus_q.delete();
        end
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_bus"}, 64'(w_vec), 64'(IDLE_VEC));
        chk({name, "_ready"}, 64'(oReqReady), 64'(0));
        chk({name, "_rspvalid"}, 64'(oRspValid), 64'(0));
        chk({name, "_rsp"}, 64'({oRspErr, oRspData}), 64'(0));
        chk({name, "_busclk"}, 64'(oBusClk), 64'(1));
    endtask

    initial begin : driver
        bit b2b;
        iReset = 1'b1;
        iReqValid = 1'b0;
        iReady = 1'b1;
        iAd = 8'h00;
        garbage();
        repeat (3) @(negedge iClk);
        chk_reset_state("reset");
        iReset = 1'b0;
        @(negedge iClk);
        chk("ready_after_reset", 64'(oReqReady), 64'(1));
        chk_en = 1'b1;

        issue(20'hABCDE, 8'h11, 1'b0, 1'b0, 0, 8'h5A, 1'b0);
        idle(2);
        issue(20'hF002A, 8'h3C, 1'b1, 1'b1, 0, 8'h00, 1'b0);
        idle(1);
        issue(20'h12345, 8'h00, 1'b0, 1'b0, 3, 8'hC3, 1'b0);
        idle(1);
        issue(20'h54321, 8'h00, 1'b0, 1'b0, 9, 8'h77, 1'b1);
        issue(20'h0BEEF, 8'h96, 1'b1, 1'b0, 1, 8'h00, 1'b1);
        issue(20'h3F00D, 8'h00, 1'b0, 1'b1, 0, 8'hA5, 1'b0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            b2b = (i != 39) && ($urandom_range(0, 1) == 1);
            issue(20'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
                  8'($urandom), b2b);
            if (!b2b) idle($urandom_range(0, 3));
        end
        drain();

        // Reset in the middle of a read: bus must drop to idle with no response.
        idle(2);
        chk_en = 1'b0;
        idle(1);
        iReqValid = 1'b1;
        iReqWr = 1'b0;
        iReqIo = 1'b0;
        iReady = 1'b1;
        for (int n = 0; n < 50 && !oReqReady; n++) @(negedge iClk);
        chk("rst_test_ready", 64'(oReqReady), 64'(1));
        @(negedge iClk);
        iReqValid = 1'b0;
        repeat (2 * T) @(negedge iClk);
        chk("rst_test_active", 64'(oSso), 64'(0));
        iReset = 1'b1;
        @(negedge iClk);
        chk_reset_state("midreset");
        iReset = 1'b0;
        @(negedge iClk);
        chk("ready_after_midreset", 64'(oReqReady), 64'(1));
        chk_en = 1'b1;
        idle(12);
        issue(20'h00F0F, 8'h00, 1'b0, 1'b0, 2, 8'h3E, 1'b0);
        drain();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/v20_bus_master.md
Name: v20_bus_master

Overview:
- Bus-cycle initiator for the NEC V20 min-mode multiplexed bus: the opposite end of the FPGA-side bus bridge, which responds to V20 cycles.
- Accepts single-byte memory/IO read/write requests on an internal valid/ready interface and generates the T1-T4 sequence (ALE, multiplexed AD, AH, IOM, DTR, SSO) with READY wait states.
- Used as a V20 stand-in for bridge bring-up and loopback test.
- Also usable to drive 8088-style bus peripherals.

Parameters:
TSTATE_CLKS, 2, iClk cycles per T-state; even, >=2; oBusClk period equals one T-state.
WAIT_MAX, 255, max consecutive TW states before abort; 8-bit counter.

Ports:
iClk  in  1  system clock (10 MHz)
iReset  in  1  synchronous, active-high reset
iReqValid  in  1  request valid
oReqReady  out  1  request accepted when high with iReqValid
iReqAddr  in  20  byte address; IO uses [15:0]
iReqData  in  8  write data
iReqWr  in  1  1=write, 0=read
iReqIo  in  1  1=IO, 0=memory
oRspValid  out  1  one-cycle completion pulse
oRspData  out  8  read data (0 for writes, 8'hFF on error)
oRspErr  out  1  wait timeout; valid with oRspValid
oBusClk  out  1  bus clock, high for first half of each T-state
oAle  out  1  address latch enable
oSso  out  1  0 during an active cycle (T1-T4), 1 otherwise
oIom  out  1  1=IO, 0=memory
oDtr  out  1  1=write, 0=read
oAh  out  12  upper address A19:A8
oAd  out  8  AD7:AD0 drive value
oAdOe  out  1  1=master drives AD, 0=released
iAd  in  8  AD7:AD0 sampled value
iReady  in  1  slave ready; 0 inserts wait states

Behaviour:
- States: IDLE, T1, T2, T3, TW, T4. T1, T2, T3, TW and T4 each last exactly TSTATE_CLKS cycles. A phase counter runs continuously; oBusClk = (phase < TSTATE_CLKS/2).
- Reset, synchronous: state=IDLE, phase=0, oReqReady=0, oRspValid=0, oRspData=0, oRspErr=0, oAle=0, oSso=1, oIom=0, oDtr=0, oAh=0, oAd=0, oAdOe=0. oReqReady rises the first cycle after iReset falls.
- IDLE:
  - oReqReady=1; the bus outputs hold their reset values.
  - Accept on iReqValid&oReqReady: latch addr/data/wr/io, set oReqReady=0.
  - T1 starts the next cycle with phase aligned to 0.
- T1:
  - oAle=1; oAdOe=1; oAd=addr[7:0]; oAh=addr[19:8].
  - For IO, oAh[11:8]=0.
  - oIom and oDtr are set from the request; oSso=0.
  - oIom, oDtr, oAh and oSso hold through T4.
- T2..T4:
  - oAle=0.
  - Write: oAdOe=1 and oAd=data through the end of T4.
  - Read: oAdOe=0 and oAd=0 from the first cycle of T2.
- Ready and wait states:
  - iReady is sampled on the last cycle of T3 and on the last cycle of each TW.
  - 1 -> T4; 0 -> TW and the wait counter increments.
- Read capture: iAd is captured into oRspData on the same last cycle where iReady=1.
- Timeout: if the wait counter reaches WAIT_MAX while iReady=0, go to T4 with the error flag set and no capture. oRspData=8'hFF, oRspErr=1.
- Completion:
  - On the cycle after the last cycle of T4: oRspValid=1 for one cycle and state=IDLE.
  - In that cycle oReqReady=1 and the bus outputs return to idle values.
  - oRspData and oRspErr hold until the next completion.
  - Writes return oRspData=0.
- Latency: with no waits, oRspValid occurs 4*TSTATE_CLKS+1 cycles after the accept edge (9 at default). Each TW adds TSTATE_CLKS.
- Back-to-back: a request presented during the oRspValid cycle is accepted in that cycle. The next T1 starts on the following cycle.
- Request input stability: the request inputs are ignored outside the accept cycle; changes mid-cycle have no effect.
- Reset mid-cycle: abort immediately to reset values. No oRspValid is generated and AD is released.
- Non-zero iReqAddr[19:16] on IO requests: ignored, not an error.

Test Plan:
- Memory read, iReqAddr=20'hABCDE, iReady=1, iAd=8'h5A from T2 -> T1: oAle=1, oAd=8'hDE, oAh=12'hABC, oIom=0, oDtr=0, oSso=0. oAdOe=0 from T2. oRspValid 9 cycles after accept, oRspData=8'h5A, oRspErr=0.
- IO write, addr=20'hF002A, data=8'h3C -> oAh=12'h000 and oAd=8'h2A in T1. oAd=8'h3C and oAdOe=1 through T4. oIom=1, oDtr=1, oRspData=0.
- Memory read with iReady=0 for 3 READY samples, then 1 -> exactly 3 TW states; oRspValid at cycle 15; data captured on the ready sample.
- WAIT_MAX=4, iReady stuck 0 -> 4 TW then T4; oRspErr=1, oRspData=8'hFF; returns to IDLE and accepts the next request.
- Back-to-back write then read with iReqValid held high -> second accept in the oRspValid cycle. The second T1 follows with no extra idle, and oAle pulses once per cycle.
- iReset asserted during T3 of a read -> next cycle all outputs at reset values, oSso=1, oAdOe=0, no oRspValid. oReqReady=1 one cycle after reset drops.
